// File: rtl/step_move_scheduler.sv
// Coordinated two-joint move sequencer: latches joint angles, runs the angle-to-steps
// conversion handshake, then emits Bresenham-interpolated STEP/DIR trains to both drivers.
module step_move_scheduler #(
  parameter int STEP_PERIOD  = 5000,
  parameter int PULSE_WIDTH  = 100,
  parameter int CALC_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic signed [12:0] th1_in,
  input  logic signed [12:0] th2_in,
  output logic signed [12:0] calc_th1,
  output logic signed [12:0] calc_th2,
  output logic               calc_en,
  input  logic               calc_ready,
  input  logic        [8:0]  calc_steps1,
  input  logic        [8:0]  calc_steps2,
  input  logic               calc_dir1,
  input  logic               calc_dir2,
  output logic               step1,
  output logic               step2,
  output logic               dir1,
  output logic               dir2,
  output logic               busy,
  output logic               done,
  output logic               error
);

  typedef enum logic [2:0] {IDLE, CALC, WAIT, MOVE, DONE} state_t;

  localparam logic [15:0] PERIOD_LAST  = 16'(STEP_PERIOD - 1);
  localparam logic [15:0] PULSE_LAST   = 16'(PULSE_WIDTH - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(CALC_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt;
  logic [15:0] period_cnt;
  logic [15:0] pulse_cnt;
  logic [8:0]  s1, s2;
  logic [8:0]  tick_cnt;
  logic [9:0]  acc;
  logic        pulse_on;
  logic        aborting;

  logic        major_is_1;
  logic [8:0]  n_major, m_minor;
  logic [10:0] acc_step;
  logic        minor_fire;
  logic        accept, latch, timeout, stop_req, tick, pulse_end;

  // Minor-axis accumulator advance: {fire, new_acc}. acc < N <= 511 and m <= 511,
  // so the 10-bit sum cannot overflow.
  function automatic logic [10:0] acc_advance(input logic [9:0] acc_cur,
                                              input logic [8:0] minor,
                                              input logic [8:0] major);
    logic [9:0] sum;
    sum = acc_cur + {1'b0, minor};
    if (sum >= {1'b0, major})
      return {1'b1, sum - {1'b0, major}};
    return {1'b0, sum};
  endfunction

  assign major_is_1 = (s1 >= s2);
  assign n_major    = major_is_1 ? s1 : s2;
  assign m_minor    = major_is_1 ? s2 : s1;
  assign acc_step   = acc_advance(acc, m_minor, n_major);
  assign minor_fire = acc_step[10];

  assign accept    = (state == IDLE) && start;
  assign latch     = (state == WAIT) && !abort && calc_ready;
  assign timeout   = (state == WAIT) && !abort && !calc_ready && (wait_cnt == TIMEOUT_LAST);
  assign stop_req  = abort || aborting;
  assign pulse_end = pulse_on && (pulse_cnt == 16'd0);
  assign tick      = (state == MOVE) && !stop_req && (period_cnt == PERIOD_LAST) &&
                     (tick_cnt != n_major);

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign calc_en = (state == CALC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: state_nxt = abort ? IDLE : WAIT;
      WAIT: begin
        if (abort)
          state_nxt = IDLE;
        else if (calc_ready)
          state_nxt = (calc_steps1 == 9'd0 && calc_steps2 == 9'd0) ? DONE : MOVE;
        else if (wait_cnt == TIMEOUT_LAST)
          state_nxt = IDLE;
      end
      MOVE: begin
        // An abort lets a pulse already on the pins finish before leaving.
        if (stop_req) begin
          if (!pulse_on || pulse_end) state_nxt = IDLE;
        end else if (pulse_end && tick_cnt == n_major) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      calc_th1   <= '0;
      calc_th2   <= '0;
      error      <= 1'b0;
      wait_cnt   <= '0;
      s1         <= '0;
      s2         <= '0;
      dir1       <= 1'b0;
      dir2       <= 1'b0;
      period_cnt <= '0;
      tick_cnt   <= '0;
      acc        <= '0;
      pulse_on   <= 1'b0;
      pulse_cnt  <= '0;
      step1      <= 1'b0;
      step2      <= 1'b0;
      aborting   <= 1'b0;
    end else begin
      if (accept) begin
        calc_th1 <= th1_in;
        calc_th2 <= th2_in;
        error    <= 1'b0;
      end else if (timeout) begin
        error <= 1'b1;
      end

      if (state == CALC)      wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 16'd1;

      if (latch) begin
        s1         <= calc_steps1;
        s2         <= calc_steps2;
        dir1       <= calc_dir1;
        dir2       <= calc_dir2;
        period_cnt <= '0;
        tick_cnt   <= '0;
        acc        <= '0;
      end else if (state == MOVE) begin
        period_cnt <= (period_cnt == PERIOD_LAST) ? 16'd0 : period_cnt + 16'd1;
      end

      // Tick launches both pulses together; they also end together, so the two
      // outputs only ever change on shared edges.
      if (tick) begin
        tick_cnt  <= tick_cnt + 9'd1;
        acc       <= acc_step[9:0];
        step1     <= major_is_1 ? 1'b1 : minor_fire;
        step2     <= major_is_1 ? minor_fire : 1'b1;
        pulse_on  <= 1'b1;
        pulse_cnt <= PULSE_LAST;
      end else if (pulse_end) begin
        step1    <= 1'b0;
        step2    <= 1'b0;
        pulse_on <= 1'b0;
      end else if (pulse_on) begin
        pulse_cnt <= pulse_cnt - 16'd1;
      end

      aborting <= (state == MOVE) && (state_nxt == MOVE) && stop_req;
    end
  end

endmodule

// File: tb/tb_step_move_scheduler.sv
// Self-checking bench for step_move_scheduler: models the conversion unit and predicts
// every STEP/DIR/done/busy cycle from the move rules using plain arithmetic.
module tb_step_move_scheduler;

  localparam int P  = 8;
  localparam int PW = 2;
  localparam int TO = 64;

  logic               clk, reset, start, abort;
  logic signed [12:0] th1_in, th2_in, calc_th1, calc_th2;
  logic               calc_en, calc_ready;
  logic        [8:0]  calc_steps1, calc_steps2;
  logic               calc_dir1, calc_dir2;
  logic               step1, step2, dir1, dir2, busy, done, error;

  int tests = 0;
  int fails = 0;

  step_move_scheduler #(.STEP_PERIOD(P), .PULSE_WIDTH(PW), .CALC_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .th1_in(th1_in), .th2_in(th2_in), .calc_th1(calc_th1), .calc_th2(calc_th2),
    .calc_en(calc_en), .calc_ready(calc_ready),
    .calc_steps1(calc_steps1), .calc_steps2(calc_steps2),
    .calc_dir1(calc_dir1), .calc_dir2(calc_dir2),
    .step1(step1), .step2(step2), .dir1(dir1), .dir2(dir2),
    .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Minor axis pulses on major tick k when floor(k*m/N) advances.
  function automatic bit minor_fires(input int k, input int m, input int n);
    return ((k * m) / n) != (((k - 1) * m) / n);
  endfunction

  task automatic run_move(input int s1, input int s2, input bit d1, input bit d2,
                          input int dly, input int abort_c, input int reset_c);
    int n, m, done_c, idle_c, lim, k, r;
    bit maj1, hi, mhi;
    logic signed [12:0] t1, t2;
    maj1   = (s1 >= s2);
    n      = maj1 ? s1 : s2;
    m      = maj1 ? s2 : s1;
    done_c = (n == 0) ? 1 : n * P + PW + 1;
    idle_c = done_c + 1;
    if (abort_c > 0) begin
      k = (abort_c - 1) / P;
      r = (abort_c - 1) % P;
      idle_c = (k >= 1 && k <= n && r < PW) ? k * P + PW + 1 : abort_c + 1;
    end
    lim = (reset_c > 0) ? reset_c : idle_c + 1;
    t1 = 13'($urandom);
    t2 = 13'($urandom);
    th1_in = t1; th2_in = t2; start = 1'b1;
    @(negedge clk) chk("idle_busy", busy, 0);
    @(posedge clk) #1;
    start = 1'b0; th1_in = 13'($urandom); th2_in = 13'($urandom);
    @(negedge clk);
    chk("calc_en_pulse", calc_en, 1);
    chk("error_cleared", error, 0);
    chk("calc_th1", calc_th1, t1);
    chk("calc_th2", calc_th2, t2);
    @(posedge clk) #1;
    for (int j = 0; j < dly; j++) begin
      @(negedge clk);
      chk("wait_calc_en", calc_en, 0);
      chk("wait_busy", busy, 1);
      @(posedge clk) #1;
    end
    calc_ready = 1'b1; calc_steps1 = 9'(s1); calc_steps2 = 9'(s2);
    calc_dir1 = d1; calc_dir2 = d2;
    @(posedge clk) #1;
    calc_ready = 1'b0; calc_steps1 = 9'($urandom); calc_steps2 = 9'($urandom);
    calc_dir1 = 1'($urandom); calc_dir2 = 1'($urandom);
    for (int c = 1; c <= lim; c++) begin
      abort = (c == abort_c);
      start = (c == 3) && (3 < idle_c);
      k   = (c - 1) / P;
      r   = (c - 1) % P;
      hi  = (c < idle_c) && k >= 1 && k <= n && r < PW;
      mhi = hi && minor_fires(k, m, n);
      @(negedge clk);
      chk("step1", step1, maj1 ? hi : mhi);
      chk("step2", step2, maj1 ? mhi : hi);
      chk("done", done, (abort_c == 0) && (c == done_c));
      chk("busy", busy, c < idle_c);
      chk("dir1", dir1, d1);
      chk("dir2", dir2, d2);
      chk("no_calc_en", calc_en, 0);
      @(posedge clk) #1;
    end
    abort = 1'b0;
    start = 1'b0;
    chk("calc_th1_held", calc_th1, t1);
    if (reset_c > 0) begin
      k  = reset_c / P;
      hi = k >= 1 && (reset_c % P) < PW;
      chk("pre_reset_major", maj1 ? step1 : step2, hi);
      #1 reset = 1'b1;
      #1;
      chk("rst_step1", step1, 0);
      chk("rst_step2", step2, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dir1", dir1, 0);
      chk("rst_calc_th1", calc_th1, 0);
      #1 reset = 1'b0;
      @(posedge clk) #1;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; th1_in = '0; th2_in = '0;
    calc_ready = 1'b0; calc_steps1 = '0; calc_steps2 = '0; calc_dir1 = 1'b0; calc_dir2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_step1", step1, 0);
    chk("reset_step2", step2, 0);
    chk("reset_dir", {dir1, dir2}, 0);
    chk("reset_flags", {busy, done, error, calc_en}, 0);
    chk("reset_calc_th", {calc_th1, calc_th2}, 0);
    @(posedge clk) #1;

    run_move(10, 4, 1'b1, 1'b0, 28, 0, 0);
    run_move(0, 0, 1'b1, 1'b1, 5, 0, 0);
    run_move(3, 7, 1'b0, 1'b1, 3, 0, 0);
    run_move(511, 511, 1'b1, 1'b1, 0, 0, 0);

    // Conversion timeout: error after exactly TO wait cycles, no done.
    th1_in = 13'sd100; th2_in = -13'sd50; start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    @(negedge clk) chk("to_calc_en", calc_en, 1);
    @(posedge clk) #1;
    for (int j = 0; j < TO; j++) begin
      @(negedge clk);
      chk("to_error_low", error, 0);
      chk("to_busy", busy, 1);
      @(posedge clk) #1;
    end
    @(negedge clk);
    chk("to_error_set", error, 1);
    chk("to_idle", busy, 0);
    chk("to_no_done", done, 0);
    @(posedge clk) #1 calc_ready = 1'b1; calc_steps1 = 9'd5;
    @(posedge clk) #1 calc_ready = 1'b0;
    @(negedge clk);
    chk("late_ready_ignored", busy, 0);
    chk("error_sticky", error, 1);
    @(posedge clk) #1;
    run_move(6, 6, 1'b0, 1'b0, 10, 0, 0);

    for (int i = 0; i < 6; i++)
      run_move($urandom_range(0, 40), $urandom_range(0, 40), 1'($urandom), 1'($urandom),
               $urandom_range(0, 60), 0, 0);

    run_move(10, 4, 1'b1, 1'b1, 2, P + 1, 0);
    run_move(4, 9, 1'b0, 1'b1, 1, 3 * P + 2, 0);
    run_move(7, 2, 1'b1, 1'b0, 4, 2 * P - 2, 0);

    // Abort while waiting for the conversion; a late calc_ready must not restart anything.
    th1_in = 13'sd7; start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk) #1 abort = 1'b0;
    @(negedge clk) chk("abort_wait_idle", busy, 0);
    @(posedge clk) #1 calc_ready = 1'b1; calc_steps1 = 9'd3; calc_steps2 = 9'd3;
    @(posedge clk) #1 calc_ready = 1'b0;
    repeat (P + 3) begin
      @(negedge clk);
      chk("abort_wait_quiet", {busy, done, step1, step2}, 0);
      @(posedge clk) #1;
    end

    run_move(10, 4, 1'b1, 1'b1, 2, 0, P + 1);
    run_move(5, 2, 1'b1, 1'b0, 3, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
